mem_portb_arbiter: RTL
======================

// Module: mem_portb_arbiter
// PURPOSE
//  Shares the read/write port B of the dual-port BRAM main memory between two masters.
//  m0 is the CPU load/store unit. m1 is the debug/program loader.
//  Uses round-robin arbitration with an optional per-master lock for atomic multi-beat sequences.
//  Sits between the masters and the memory port-B pins; port A (ifetch) is untouched.
// PARAMETERS
//  MEM_SIZE  8192               memory size in bytes; must match the memory instance
//  AW        $clog2(MEM_SIZE)   byte-address width (derived; do not override)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   asynchronous reset, active-high
//  mN_req_valid   in   1   master N (N=0,1) request valid
//  mN_req_ready   out  1   request accepted this cycle (== grant to N)
//  mN_req_addr    in   AW  byte address; bits [1:0] ignored by memory
//  mN_req_wdata   in   32  write data
//  mN_req_be      in   4   byte enables, lane i = bits [8i+7:8i]
//  mN_req_we      in   1   1 = write, 0 = read
//  mN_req_lock    in   1   hold grant after this beat
//  mN_rsp_valid   out  1   response for N's accepted beat
//  mN_rsp_rdata   out  32  read data (writes: pre-write word)
//  mem_addr       out  AW  to memory addr_b
//  mem_wdata      out  32  to memory data_i_b
//  mem_be         out  4   to memory data_en_b
//  mem_we         out  1   to memory write_en_b
//  mem_rdata      in   32  from memory data_o_b (registered, 1-cycle latency)
// BEHAVIOUR
//  - Reset values:
//    - state=ARB; rr_next=m0; rsp_pend=0.
//    - mN_rsp_valid=0; mN_rsp_rdata=0; mN_req_ready=0.
//    - mem_we=0; mem_be=0; mem_addr=0; mem_wdata=0.
//  - Grant logic is combinational from valid/state; mN_req_ready = grant_N.
//    - At most one grant per cycle. Beat accepted when valid&&ready.
//  - Memory outputs mux the granted master's fields.
//    - With no grant: mem_we=0 and mem_be=0; addr/wdata driven 0.
//  - FSM states {ARB, LOCK0, LOCK1}:
//    - ARB, one valid: grant it.
//    - ARB, both valid: grant rr_next; rr_next := other master.
//    - ARB, single grant: rr_next := non-granted master.
//    - Accepted beat with lock=1 -> LOCKN (N = granted master).
//    - LOCKN: only N may be granted; other master's ready=0, even if N idles.
//    - LOCKN: accepted beat with lock=0 -> ARB, rr_next := other master.
//    - No timeout; N owns release.
//  - Response pipeline, latency exactly 1 cycle:
//    - Accepted at edge k -> mN_rsp_valid=1 during cycle k+1.
//    - mN_rsp_rdata = mem_rdata during cycle k+1, combinational passthrough.
//    - rsp_owner is registered at edge k.
//  - rsp_valid pulses for reads and writes alike.
//    - Write response data is the old word (memory is read-first).
//  - No response backpressure; masters must sink rsp in that cycle.
//  - Throughput: one beat per cycle sustained.
//    - Back-to-back beats from alternating masters each get their own rsp cycle.
//  - Non-owner: rsp_valid=0 and rsp_rdata=0.
//  - Simultaneous events:
//    - Both masters request, same word, in ARB: rr order; loser sees winner's write next cycle.
//    - Lock requested by both in the same cycle: only the granted one locks.
//  - Reset mid-operation: async clear of rsp_pend/state.
//    - No rsp_valid emitted for beats accepted before reset.
//    - Memory contents are not reset.
//    - A write sampled on the same edge as reset deassertion is not issued.
// STRUCTURE
//  - Package mem_arb_pkg:
//    - arb_state_t enum {ARB, LOCK0, LOCK1}.
//    - mem_req_t struct {addr, wdata, be, we, lock}.
//    - localparam RSP_LATENCY = 1.
//  - Sub-module rr_arb2 (combinational 2-way round-robin):
//    - Inputs: req[1:0], prio, mask[1:0]. Output: onehot gnt[1:0].
//  - Top holds the FSM, rr_next, rsp_owner/rsp_pend registers, request mux and response demux.
// TESTING (bench instantiates memory + arbiter; checks against a byte-lane scoreboard)
//  1. Reset, then m0 writes addr 0x10 data 0xDEADBEEF be=4'hF.
//     Next, m0 reads 0x12: rsp_valid one cycle later, rdata=0xDEADBEEF.
//  2. Both masters valid every cycle for 6 cycles, no lock.
//     Grants m0,m1,m0,m1,m0,m1; each rsp_valid on its owner exactly 1 cycle after its grant.
//  3. m1 issues 3 beats with lock=1,1,0 while m0 is held valid.
//     m0_ready=0 for all 3 beats and any m1 idle cycles between; m0 granted the cycle after the lock=0 beat.
//  4. Write 0x11223344 to 0x20, then m0 writes be=4'b0100 data 0xAABBCCDD to 0x20.
//     Write rsp rdata=0x11223344; subsequent read returns 0x11BB3344.
//  5. m0 reads 0x20 same cycle m1 writes 0x20 (rr_next=m1).
//     m1 granted first; m0 read next cycle returns m1's data.
//  6. Assert rst in the cycle after an accepted read.
//     No rsp_valid asserted; after release, state=ARB, rr_next=m0, all outputs 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the port-B memory arbiter.
//  arb_state_t : arbiter FSM state (free arbitration or locked to one master)
//  mem_req_t   : one master's request fields, muxed onto the memory pins
//  RSP_LATENCY : cycles from accepted beat to response (memory read latency)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  // Address field is sized for the largest supported memory; the top slices it down.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic        lock;
  } mem_req_t;

  localparam int unsigned RSP_LATENCY = 1;

  function automatic arb_state_t lock_state(input logic idx);
    return idx ? LOCK1 : LOCK0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin arbiter.
//  req  : request lines
//  prio : master that wins when both eligible requests collide (0 = m0, 1 = m1)
//  mask : which masters may be granted at all this cycle
//  gnt  : one-hot (or zero) grant
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] elig;

  always_comb begin
    elig = req & mask;
    gnt  = elig;
    if (&elig) begin
      gnt = prio ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_portb_arbiter.sv
// Shares BRAM port B between the CPU load/store unit (m0) and the debug loader (m1).
// Round-robin arbitration, with an optional lock that keeps the grant on one master
// across a multi-beat sequence until that master issues a beat with lock=0.
//  clk, rst          : clock, asynchronous active-high reset
//  mN_req_*          : master N request (valid/ready handshake, ready == grant)
//  mN_rsp_valid/rdata: response one cycle after acceptance (writes return the old word)
//  mem_*             : memory port-B pins (mem_rdata registered, 1-cycle latency)
module mem_portb_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 8192,
  parameter int unsigned AW       = $clog2(MEM_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req_valid,
  output logic          m0_req_ready,
  input  logic [AW-1:0] m0_req_addr,
  input  logic [31:0]   m0_req_wdata,
  input  logic [3:0]    m0_req_be,
  input  logic          m0_req_we,
  input  logic          m0_req_lock,
  output logic          m0_rsp_valid,
  output logic [31:0]   m0_rsp_rdata,
  input  logic          m1_req_valid,
  output logic          m1_req_ready,
  input  logic [AW-1:0] m1_req_addr,
  input  logic [31:0]   m1_req_wdata,
  input  logic [3:0]    m1_req_be,
  input  logic          m1_req_we,
  input  logic          m1_req_lock,
  output logic          m1_rsp_valid,
  output logic [31:0]   m1_rsp_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata
);

  arb_state_t             state_q, state_d;
  logic                   rr_next_q, rr_next_d;
  logic [RSP_LATENCY-1:0] rsp_pend_q;
  logic                   rsp_pend_d;
  logic                   rsp_owner_q, rsp_owner_d;

  logic [1:0] req_vec;
  logic [1:0] mask;
  logic [1:0] gnt;
  logic       any_gnt;
  mem_req_t   req0, req1, req_sel;
  logic       unused_addr_hi;

  // Grants are suppressed while reset is held so a beat presented across the
  // reset release edge is never issued to memory.
  assign req_vec = {m1_req_valid, m0_req_valid} & {2{~rst}};

  rr_arb2 u_rr_arb2 (
    .req  (req_vec),
    .prio (rr_next_q),
    .mask (mask),
    .gnt  (gnt)
  );

  assign any_gnt      = |gnt;
  assign m0_req_ready = gnt[0];
  assign m1_req_ready = gnt[1];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      rr_next_q   <= 1'b0;
      rsp_pend_q  <= '0;
      rsp_owner_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_next_q   <= rr_next_d;
      rsp_pend_q  <= rsp_pend_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end

  // Next state: every accepted beat hands priority to the other master, and the
  // beat's lock bit decides whether the grant stays pinned to its issuer.
  always_comb begin
    state_d     = state_q;
    rr_next_d   = rr_next_q;
    rsp_pend_d  = any_gnt;
    rsp_owner_d = gnt[1];
    if (any_gnt) begin
      rr_next_d = ~gnt[1];
      state_d   = req_sel.lock ? lock_state(gnt[1]) : ARB;
    end
  end

  // Output decode: which masters may be granted in the current state.
  always_comb begin
    mask = 2'b11;
    unique case (state_q)
      ARB:     mask = 2'b11;
      LOCK0:   mask = 2'b01;
      LOCK1:   mask = 2'b10;
      default: mask = 2'b11;
    endcase
  end

  // Request mux onto the memory pins.
  always_comb begin
    req0 = '{addr: 32'(m0_req_addr), wdata: m0_req_wdata, be: m0_req_be,
             we: m0_req_we, lock: m0_req_lock};
    req1 = '{addr: 32'(m1_req_addr), wdata: m1_req_wdata, be: m1_req_be,
             we: m1_req_we, lock: m1_req_lock};
    req_sel = '0;
    if (gnt[0]) begin
      req_sel = req0;
    end else if (gnt[1]) begin
      req_sel = req1;
    end
  end

  assign mem_addr       = req_sel.addr[AW-1:0];
  assign mem_wdata      = req_sel.wdata;
  assign mem_be         = req_sel.be;
  assign mem_we         = req_sel.we & any_gnt;
  assign unused_addr_hi = ^req_sel.addr;

  // Response demux: the memory's registered read data passes straight through to
  // whichever master owned the beat accepted on the previous edge.
  always_comb begin
    m0_rsp_valid = rsp_pend_q[RSP_LATENCY-1] & ~rsp_owner_q;
    m1_rsp_valid = rsp_pend_q[RSP_LATENCY-1] & rsp_owner_q;
    m0_rsp_rdata = m0_rsp_valid ? mem_rdata : 32'h0;
    m1_rsp_rdata = m1_rsp_valid ? mem_rdata : 32'h0;
  end

endmodule
